bus_loads_8bit: RTL and testbench
=================================

# bus_loads_8bit

Receiving end of the 8-bit Main bus: holds the general-purpose registers A, B, C, D and the 16-bit transfer register TX, and captures MainBus into them on active-low load strobes at the rising clock edge. Register contents are fed back to the 8-bit bus driver MUX, so the two blocks together form the complete Main-bus path. The block also flags loads taken from an undriven bus and, optionally, monitors the driver asserts for contention.

## Interface
- RESET_VAL, 8'h00, reset value of A, B, C, D, TXH and TXL.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- MainBus  input  8  Main bus value from the driver MUX.
- RegA_Load_Main, RegB_Load_Main, RegC_Load_Main, RegD_Load_Main  input  1 each  active-low load strobes.
- RegTXH_Load_Main, RegTXL_Load_Main  input  1 each  active-low byte loads of TX[15:8] and TX[7:0].
- TX_Inc  input  1  active-low; TX increments by 1, wrapping modulo 2^16.
- Asserts_Main  input  8  active-low driver asserts {TXL,TXH,Const,D,C,B,A,ALU}, bit 0 = ALU.
- Asserts_LHS  input  4  active-low LHS asserts {D,C,B,A}.
- Asserts_RHS  input  4  active-low RHS asserts {D,C,B,A}.
- RegA_Out, RegB_Out, RegC_Out, RegD_Out  output  8 each  register contents.
- TX_Reg  output  16  TX contents.
- Float_Load  output  1  registered one-cycle pulse after a load taken from an undriven bus.
- Contention_Err  output  1  sticky contention flag.
- Contention_Count  output  8  saturating contention counter.

## Operation
- Each register updates only on an edge where its strobe is 0. Several strobes may be low together, and every selected register captures the same MainBus value.
- An undriven bus is Asserts_Main == 8'hFF. A load under that condition captures MainBus as presented (8'h00 from the driver), and Float_Load is 1 on the next cycle only.
- TX update priority on one edge, applied per byte:
  - A byte whose load strobe is low takes MainBus.
  - If either TX byte load is low, TX_Inc is ignored for the whole register on that edge. There is no partial increment.
  - Otherwise, if TX_Inc is low, TX <= TX + 1. 16'hFFFF wraps to 16'h0000.
- Contention, when the check is compiled in: on any cycle where two or more bits of Asserts_Main are 0, or two or more bits of Asserts_LHS, or two or more bits of Asserts_RHS:
  - Contention_Err sets and stays at 1 until rst.
  - Contention_Count increments and saturates at 8'hFF.
  - Several buses in contention on the same cycle count once.
- The register-load path has no FSM. The contention monitor has two states: CLEAN and FAULT.
  - CLEAN -> FAULT on the first contention edge.
  - FAULT holds until rst.

## Timing
- Latency of one clock. A value on MainBus at edge N is visible on the outputs after edge N; no combinational path exists from MainBus to any output.
- Float_Load, Contention_Err and Contention_Count are all registered and update on the same edge that observes the condition.
- Reset values are driven on the first edge with rst=1:
  - A, B, C, D, TXH and TXL all take RESET_VAL, so TX_Reg = {RESET_VAL, RESET_VAL}.
  - Float_Load = 0, Contention_Err = 0, Contention_Count = 0.
- rst overrides every strobe, TX_Inc and the contention logic in the same cycle. A load or increment coinciding with rst is lost.
- A strobe held low for k cycles reloads on each of the k edges, so the register tracks MainBus during that time.

## Configuration
- BUS_CONTENTION_CHECK_EN defined: the contention monitor is built as described.
- Not defined:
  - Contention_Err and Contention_Count are tied to 0.
  - Asserts_LHS and Asserts_RHS are unused.
  - Asserts_Main is used only for Float_Load detection.
  - Register behaviour is identical in both builds.

## Test plan
- Reset, then MainBus=8'h5A with RegB_Load_Main=0 and Asserts_Main=8'hFD for 1 cycle -> RegB_Out=8'h5A next cycle; A, C, D stay 8'h00; Float_Load=0.
- MainBus=8'h3C with A and D strobes both low -> RegA_Out=RegD_Out=8'h3C; RegB_Out and RegC_Out unchanged.
- TX=16'hFFFF, TX_Inc=0 for one edge -> TX_Reg=16'h0000. Then TXL load of 8'h10 together with TX_Inc=0 -> TX_Reg=16'h0010, with no increment.
- RegC_Load_Main=0 with Asserts_Main=8'hFF and MainBus=8'h00 -> RegC_Out=8'h00 and a Float_Load pulse exactly one cycle wide.
- With BUS_CONTENTION_CHECK_EN defined:
  - Asserts_Main=8'hFC for 3 cycles -> Contention_Count=3 and Contention_Err=1, which remains 1 after the asserts clear.
  - Sustaining contention for 300 cycles -> count holds at 8'hFF.
  - Without the macro, the same stimulus -> both outputs stay 0.
- rst=1 asserted on the same edge as RegA_Load_Main=0 and MainBus=8'hAA -> RegA_Out=8'h00 and all flags cleared.

Source files
------------

// File: rtl/bus_loads_8bit_if.sv
// Main-bus bundle: bus value, active-low load strobes, TX increment and driver asserts.
// The driver MUX side owns the master modport; the register file is the slave.
interface bus_loads_8bit_if;
    logic [7:0] MainBus;
    logic       RegA_Load_Main;
    logic       RegB_Load_Main;
    logic       RegC_Load_Main;
    logic       RegD_Load_Main;
    logic       RegTXH_Load_Main;
    logic       RegTXL_Load_Main;
    logic       TX_Inc;
    logic [7:0] Asserts_Main;
    logic [3:0] Asserts_LHS;
    logic [3:0] Asserts_RHS;

    // No handshake: every rising edge with a low strobe is a transfer, no back-pressure.
    modport master (
        output MainBus, RegA_Load_Main, RegB_Load_Main, RegC_Load_Main, RegD_Load_Main,
               RegTXH_Load_Main, RegTXL_Load_Main, TX_Inc, Asserts_Main, Asserts_LHS, Asserts_RHS
    );
    modport slave (
        input  MainBus, RegA_Load_Main, RegB_Load_Main, RegC_Load_Main, RegD_Load_Main,
               RegTXH_Load_Main, RegTXL_Load_Main, TX_Inc, Asserts_Main, Asserts_LHS, Asserts_RHS
    );
endinterface

// File: rtl/bus_loads_8bit.sv
// Main-bus receiving end: registers A-D and 16-bit TX with floating-bus load flag.
// Optional driver-contention monitor built when BUS_CONTENTION_CHECK_EN is defined.
module bus_loads_8bit #(
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic                   clk,
    input  logic                   rst,
    bus_loads_8bit_if.slave        bus,
    output logic [7:0]             RegA_Out,
    output logic [7:0]             RegB_Out,
    output logic [7:0]             RegC_Out,
    output logic [7:0]             RegD_Out,
    output logic [15:0]            TX_Reg,
    output logic                   Float_Load,
    output logic                   Contention_Err,
    output logic [7:0]             Contention_Count,
    output logic                   o_dbg_mon_state
);
    logic [7:0] r_a, r_b, r_c, r_d, r_txh, r_txl;
    logic       r_float;
    logic       w_any_load;
    logic       w_tx_byte_load;

    assign w_tx_byte_load = !bus.RegTXH_Load_Main || !bus.RegTXL_Load_Main;
    assign w_any_load     = !bus.RegA_Load_Main || !bus.RegB_Load_Main ||
                            !bus.RegC_Load_Main || !bus.RegD_Load_Main || w_tx_byte_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= RESET_VAL;
            r_b     <= RESET_VAL;
            r_c     <= RESET_VAL;
            r_d     <= RESET_VAL;
            r_txh   <= RESET_VAL;
            r_txl   <= RESET_VAL;
            r_float <= 1'b0;
        end else begin
            if (!bus.RegA_Load_Main) r_a <= bus.MainBus;
            if (!bus.RegB_Load_Main) r_b <= bus.MainBus;
            if (!bus.RegC_Load_Main) r_c <= bus.MainBus;
            if (!bus.RegD_Load_Main) r_d <= bus.MainBus;
            // Any TX byte load suppresses the increment for the whole register.
            if (w_tx_byte_load) begin
                if (!bus.RegTXH_Load_Main) r_txh <= bus.MainBus;
                if (!bus.RegTXL_Load_Main) r_txl <= bus.MainBus;
            end else if (!bus.TX_Inc) begin
                {r_txh, r_txl} <= {r_txh, r_txl} + 16'd1;
            end
            r_float <= w_any_load && (bus.Asserts_Main == 8'hFF);
        end
    end

    assign RegA_Out   = r_a;
    assign RegB_Out   = r_b;
    assign RegC_Out   = r_c;
    assign RegD_Out   = r_d;
    assign TX_Reg     = {r_txh, r_txl};
    assign Float_Load = r_float;

`ifdef BUS_CONTENTION_CHECK_EN
    typedef enum logic {CLEAN = 1'b0, FAULT = 1'b1} mon_state_t;

    mon_state_t r_state, w_next_state;
    logic [7:0] r_cnt;
    logic       w_contention;

    // True when two or more bits of an active-low assert vector are 0.
    function automatic logic multi_low(input logic [7:0] v);
        logic [7:0] z;
        z = ~v;
        return (z & (z - 8'd1)) != 8'd0;
    endfunction

    assign w_contention = multi_low(bus.Asserts_Main) ||
                          multi_low({4'hF, bus.Asserts_LHS}) ||
                          multi_low({4'hF, bus.Asserts_RHS});

    always_ff @(posedge clk) begin
        if (rst) r_state <= CLEAN;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            CLEAN:   if (w_contention) w_next_state = FAULT;
            FAULT:   w_next_state = FAULT;
            default: w_next_state = CLEAN;
        endcase
    end

    always_comb begin
        Contention_Err  = (r_state == FAULT);
        o_dbg_mon_state = r_state;
    end

    always_ff @(posedge clk) begin
        if (rst)                                  r_cnt <= 8'h00;
        else if (w_contention && r_cnt != 8'hFF)  r_cnt <= r_cnt + 8'd1;
    end

    assign Contention_Count = r_cnt;
`else
    logic w_unused_asserts;
    assign w_unused_asserts = ^{bus.Asserts_LHS, bus.Asserts_RHS};
    assign Contention_Err   = 1'b0;
    assign Contention_Count = 8'h00;
    assign o_dbg_mon_state  = 1'b0;
`endif
endmodule

// File: tb/tb_bus_loads_8bit.sv
// Directed bench for bus_loads_8bit: driver pushes hand-computed expected outputs per
// edge into a queue; a monitor pops and compares one entry after each rising edge.
module tb_bus_loads_8bit;
    typedef struct packed {
        logic [7:0]  a, b, c, d;
        logic [15:0] tx;
        logic        fl;
        logic        err;
        logic [7:0]  cnt;
    } out_t;

`ifdef BUS_CONTENTION_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  a_out, b_out, c_out, d_out, cnt_out;
    logic [15:0] tx_out;
    logic        fl_out, err_out, dbg_state;

    out_t exp_s;
    out_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    bus_loads_8bit_if bus ();

    bus_loads_8bit #(.RESET_VAL(8'h00)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus.slave),
        .RegA_Out         (a_out),
        .RegB_Out         (b_out),
        .RegC_Out         (c_out),
        .RegD_Out         (d_out),
        .TX_Reg           (tx_out),
        .Float_Load       (fl_out),
        .Contention_Err   (err_out),
        .Contention_Count (cnt_out),
        .o_dbg_mon_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected entry per rising edge that had stimulus pushed for it.
    initial begin
        out_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("RegA",  {8'h00, a_out},   {8'h00, e.a});
                check("RegB",  {8'h00, b_out},   {8'h00, e.b});
                check("RegC",  {8'h00, c_out},   {8'h00, e.c});
                check("RegD",  {8'h00, d_out},   {8'h00, e.d});
                check("TX",    tx_out,           e.tx);
                check("Float", {15'h0, fl_out},  {15'h0, e.fl});
                check("Err",   {15'h0, err_out}, {15'h0, e.err});
                check("Count", {8'h00, cnt_out}, {8'h00, e.cnt});
            end
        end
    end

    task automatic idle();
        bus.MainBus          = 8'h00;
        bus.RegA_Load_Main   = 1'b1;
        bus.RegB_Load_Main   = 1'b1;
        bus.RegC_Load_Main   = 1'b1;
        bus.RegD_Load_Main   = 1'b1;
        bus.RegTXH_Load_Main = 1'b1;
        bus.RegTXL_Load_Main = 1'b1;
        bus.TX_Inc           = 1'b1;
        bus.Asserts_Main     = 8'hFF;
        bus.Asserts_LHS      = 4'hF;
        bus.Asserts_RHS      = 4'hF;
    endtask

    // Queue the expected post-edge outputs, then let the edge happen.
    task automatic step();
        exp_q.push_back(exp_s);
        @(posedge clk);
        #2;
    endtask

    initial begin
        idle();
        rst   = 1'b1;
        exp_s = '0;
        #2;
        step();                                         // reset values
        rst = 1'b0;

        bus.MainBus = 8'h5A; bus.RegB_Load_Main = 1'b0; bus.Asserts_Main = 8'hFD;
        exp_s.b = 8'h5A;
        step();

        idle(); bus.MainBus = 8'h3C; bus.RegA_Load_Main = 1'b0; bus.RegD_Load_Main = 1'b0;
        bus.Asserts_Main = 8'hFE;
        exp_s.a = 8'h3C; exp_s.d = 8'h3C;
        step();

        idle(); bus.MainBus = 8'hFF; bus.RegTXH_Load_Main = 1'b0; bus.RegTXL_Load_Main = 1'b0;
        bus.Asserts_Main = 8'hBF;
        exp_s.tx = 16'hFFFF;
        step();

        idle(); bus.TX_Inc = 1'b0;                      // wrap
        exp_s.tx = 16'h0000;
        step();

        idle(); bus.MainBus = 8'h10; bus.RegTXL_Load_Main = 1'b0; bus.TX_Inc = 1'b0;
        bus.Asserts_Main = 8'h7F;
        exp_s.tx = 16'h0010;
        step();

        idle(); bus.TX_Inc = 1'b0;
        exp_s.tx = 16'h0011;
        step();

        idle(); bus.MainBus = 8'h22; bus.RegTXH_Load_Main = 1'b0; bus.TX_Inc = 1'b0;
        bus.Asserts_Main = 8'hBF;
        exp_s.tx = 16'h2211;                            // low byte not incremented
        step();

        idle(); bus.MainBus = 8'h77; bus.RegC_Load_Main = 1'b0; bus.Asserts_Main = 8'hF7;
        exp_s.c = 8'h77;
        step();

        idle(); bus.MainBus = 8'h00; bus.RegC_Load_Main = 1'b0;   // undriven bus load
        exp_s.c = 8'h00; exp_s.fl = 1'b1;
        step();

        idle();
        exp_s.fl = 1'b0;
        step();

        for (int i = 1; i <= 3; i++) begin              // strobe held: A tracks the bus
            idle(); bus.MainBus = 8'(i * 8'h11); bus.RegA_Load_Main = 1'b0;
            bus.Asserts_Main = 8'hFE;
            exp_s.a = 8'(i * 8'h11);
            step();
        end

        for (int i = 1; i <= 3; i++) begin
            idle(); bus.Asserts_Main = 8'hFC;
            exp_s.err = CHK; exp_s.cnt = CHK ? 8'(i) : 8'h00;
            step();
        end

        idle();                                         // flag sticky, count holds
        step();

        idle(); bus.Asserts_Main = 8'hFC; bus.Asserts_LHS = 4'h3; bus.Asserts_RHS = 4'h0;
        exp_s.cnt = CHK ? 8'h04 : 8'h00;                // three buses count once
        step();

        for (int j = 1; j <= 300; j++) begin
            idle(); bus.Asserts_Main = 8'hFC;
            exp_s.cnt = CHK ? ((4 + j > 255) ? 8'hFF : 8'(4 + j)) : 8'h00;
            step();
        end

        idle();
        step();

        idle(); rst = 1'b1; bus.MainBus = 8'hAA; bus.RegA_Load_Main = 1'b0;
        bus.Asserts_Main = 8'hFC; bus.TX_Inc = 1'b0;
        exp_s = '0;
        step();

        rst = 1'b0; idle();
        step();

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        #3;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
